// File: rtl/obj_motion_ctrl.sv
// obj_motion_ctrl: owns the two falling objects shown by vga_display.
// On each frame tick (falling edge of y_valid while game_en = 1) every object advances its
// WAIT -> FALL -> HIT/WAIT life cycle. An object in FALL is tested for overlap with the player box,
// and objects respawn at LFSR-random x positions.
// Optional feature: define OBJ_SCORE_EN to add an 8-bit saturating hit counter on port 'score'.

module obj_motion_ctrl #(
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned SCREEN_H   = 480,
  parameter int unsigned OBJ_W      = 40,
  parameter int unsigned OBJ_H      = 40,
  parameter int unsigned PL_W       = 80,
  parameter int unsigned PL_H       = 60,
  parameter int unsigned STEP       = 2,
  parameter int unsigned RESPAWN_FR = 30,
  parameter int unsigned HIT_FR     = 10
) (
  input  logic        clk_vga,
  input  logic        rst,
  input  logic        game_en,
  input  logic        y_valid,
  input  logic [11:0] x_begin,
  output logic [11:0] obj1_x_begin,
  output logic [11:0] obj1_y_begin,
  output logic [11:0] obj2_x_begin,
  output logic [11:0] obj2_y_begin,
  output logic        end_show1,
  output logic        end_show2,
  output logic [1:0]  hit_pulse,
  output logic [1:0]  miss_pulse
`ifdef OBJ_SCORE_EN
  ,
  output logic [7:0]  score
`endif
);

  typedef enum logic [1:0] {StWait, StFall, StHit} obj_st_e;

  // All geometry is evaluated in 13 bits so x_begin + PL_W cannot wrap.
  localparam logic [12:0] ScrH      = 13'(SCREEN_H);
  localparam logic [12:0] ObjW      = 13'(OBJ_W);
  localparam logic [12:0] ObjH      = 13'(OBJ_H);
  localparam logic [12:0] PlW       = 13'(PL_W);
  localparam logic [12:0] HitTop    = 13'(SCREEN_H - PL_H);
  localparam logic [12:0] XSpan     = 13'(SCREEN_W - OBJ_W);
  localparam logic [12:0] Step13    = 13'(STEP);
  localparam logic [5:0]  RespawnLd = 6'(RESPAWN_FR - 1);
  localparam logic [5:0]  HitLd     = 6'(HIT_FR - 1);
  localparam logic [5:0]  Obj2Init  = 6'(RESPAWN_FR / 2 - 1);

  logic        y_valid_q;
  logic        tick;
  logic [15:0] lfsr_q, lfsr_d;
  obj_st_e     st_q[2], st_d[2];
  logic [5:0]  cnt_q[2], cnt_d[2];
  logic [11:0] x_q[2], x_d[2], y_q[2], y_d[2];
  logic [1:0]  hit_q, hit_d, miss_q, miss_d;
  logic [9:0]  spawn_r[2];
  logic [12:0] spawn_x[2];
  logic        hit_c[2], miss_c[2];
  logic [12:0] xb;

  // Frame tick and free-running LFSR (keeps running while the game is frozen).
  always_comb begin
    tick   = y_valid_q & ~y_valid & game_en;
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    xb     = {1'b0, x_begin};
  end

  // Per-object spawn position and collision/miss conditions on the displayed position.
  always_comb begin
    spawn_r[0] = lfsr_q[9:0];
    spawn_r[1] = lfsr_q[15:6];
    for (int i = 0; i < 2; i++) begin
      spawn_x[i] = {3'b000, spawn_r[i]};
      if (spawn_x[i] >= XSpan) spawn_x[i] = spawn_x[i] - XSpan;
      hit_c[i]  = ({1'b0, x_q[i]} < xb + PlW) && ({1'b0, x_q[i]} + ObjW > xb) &&
                  ({1'b0, y_q[i]} + ObjH > HitTop);
      miss_c[i] = ({1'b0, y_q[i]} + Step13 + ObjH > ScrH);
    end
  end

  // Next-state logic of both object FSMs; nothing moves except on a tick.
  always_comb begin
    hit_d  = 2'b00;
    miss_d = 2'b00;
    for (int i = 0; i < 2; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      x_d[i]   = x_q[i];
      y_d[i]   = y_q[i];
      if (tick) begin
        case (st_q[i])
          StWait: begin
            if (cnt_q[i] == 6'd0) begin
              st_d[i] = StFall;
              x_d[i]  = spawn_x[i][11:0];
              y_d[i]  = 12'd0;
            end else begin
              cnt_d[i] = cnt_q[i] - 6'd1;
            end
          end
          StFall: begin
            // Hit wins over miss when both hold on the same tick.
            if (hit_c[i]) begin
              st_d[i]  = StHit;
              cnt_d[i] = HitLd;
              hit_d[i] = 1'b1;
            end else if (miss_c[i]) begin
              st_d[i]   = StWait;
              cnt_d[i]  = RespawnLd;
              miss_d[i] = 1'b1;
            end else begin
              y_d[i] = y_q[i] + 12'(STEP);
            end
          end
          StHit: begin
            if (cnt_q[i] == 6'd0) begin
              st_d[i]  = StWait;
              cnt_d[i] = RespawnLd;
            end else begin
              cnt_d[i] = cnt_q[i] - 6'd1;
            end
          end
          default: st_d[i] = StWait;
        endcase
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      y_valid_q <= 1'b0;
      lfsr_q    <= 16'hACE1;
      hit_q     <= 2'b00;
      miss_q    <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        st_q[i] <= StWait;
        x_q[i]  <= 12'd0;
        y_q[i]  <= 12'd0;
      end
      cnt_q[0] <= RespawnLd;
      cnt_q[1] <= Obj2Init;
    end else begin
      y_valid_q <= y_valid;
      lfsr_q    <= lfsr_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
        x_q[i]   <= x_d[i];
        y_q[i]   <= y_d[i];
      end
    end
  end

`ifdef OBJ_SCORE_EN
  logic [7:0] score_q, score_d;
  logic [8:0] score_sum;

  // Saturating add of this tick's hits; a double hit adds 2.
  always_comb begin
    score_sum = {1'b0, score_q} + 9'(hit_d[0]) + 9'(hit_d[1]);
    score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
  end

  // Score register.
  always_ff @(posedge clk_vga) begin
    if (rst) score_q <= 8'd0;
    else     score_q <= score_d;
  end

  assign score = score_q;
`endif

  assign obj1_x_begin = x_q[0];
  assign obj1_y_begin = y_q[0];
  assign obj2_x_begin = x_q[1];
  assign obj2_y_begin = y_q[1];
  assign end_show1    = (st_q[0] != StFall);
  assign end_show2    = (st_q[1] != StFall);
  assign hit_pulse    = hit_q;
  assign miss_pulse   = miss_q;

endmodule

// File: tb/tb_obj_motion_ctrl.sv
// Scoreboard bench for obj_motion_ctrl: the driver issues frames and pushes the expected post-tick
// outputs; a monitor pops one record per y_valid fall and compares. Spawn x positions are steered
// by padding frames until the LFSR yields a wanted x.

module tb_obj_motion_ctrl;

  localparam int MWait = 0;
  localparam int MFall = 1;
  localparam int MHit  = 2;

  logic        clk_vga = 1'b0;
  logic        rst;
  logic        game_en;
  logic        y_valid;
  logic [11:0] x_begin;
  logic [11:0] obj1_x_begin, obj1_y_begin, obj2_x_begin, obj2_y_begin;
  logic        end_show1, end_show2;
  logic [1:0]  hit_pulse, miss_pulse;
`ifdef OBJ_SCORE_EN
  logic [7:0]  score;
`endif

  always #5 clk_vga = ~clk_vga;

  obj_motion_ctrl dut (
    .clk_vga      (clk_vga),
    .rst          (rst),
    .game_en      (game_en),
    .y_valid      (y_valid),
    .x_begin      (x_begin),
    .obj1_x_begin (obj1_x_begin),
    .obj1_y_begin (obj1_y_begin),
    .obj2_x_begin (obj2_x_begin),
    .obj2_y_begin (obj2_y_begin),
    .end_show1    (end_show1),
    .end_show2    (end_show2),
    .hit_pulse    (hit_pulse),
    .miss_pulse   (miss_pulse)
`ifdef OBJ_SCORE_EN
    ,
    .score        (score)
`endif
  );

  typedef struct {
    int       x1, y1, x2, y2;
    bit       es1, es2;
    bit [1:0] hit, miss;
    int       score;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  int          m_st[2], m_cnt[2], m_x[2], m_y[2], m_score;
  bit   [1:0]  m_hit, m_miss;
  logic [15:0] m_lfsr;

  always @(posedge clk_vga) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic int spawn_pos(input logic [15:0] l, input int idx);
    int r;
    r = (idx == 0) ? int'(l[9:0]) : int'(l[15:6]);
    return (r >= 600) ? r - 600 : r;
  endfunction

  task automatic model_reset();
    m_st[0] = MWait; m_cnt[0] = 29;
    m_st[1] = MWait; m_cnt[1] = 14;
    for (int i = 0; i < 2; i++) begin m_x[i] = 0; m_y[i] = 0; end
    m_score = 0; m_hit = 0; m_miss = 0;
  endtask

  task automatic model_tick(input int xb);
    m_hit = 0; m_miss = 0;
    for (int i = 0; i < 2; i++) begin
      if (m_st[i] == MWait) begin
        if (m_cnt[i] == 0) begin m_st[i] = MFall; m_x[i] = spawn_pos(m_lfsr, i); m_y[i] = 0; end
        else m_cnt[i]--;
      end else if (m_st[i] == MFall) begin
        if (m_x[i] < xb + 80 && m_x[i] + 40 > xb && m_y[i] + 40 > 420) begin
          m_st[i] = MHit; m_cnt[i] = 9; m_hit[i] = 1'b1;
        end else if (m_y[i] + 42 > 480) begin
          m_st[i] = MWait; m_cnt[i] = 29; m_miss[i] = 1'b1;
        end else begin
          m_y[i] += 2;
        end
      end else begin
        if (m_cnt[i] == 0) begin m_st[i] = MWait; m_cnt[i] = 29; end
        else m_cnt[i]--;
      end
    end
    m_score += int'(m_hit[0]) + int'(m_hit[1]);
    if (m_score > 255) m_score = 255;
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.x1 = m_x[0]; e.y1 = m_y[0]; e.x2 = m_x[1]; e.y2 = m_y[1];
    e.es1 = (m_st[0] != MFall); e.es2 = (m_st[1] != MFall);
    e.hit = m_hit; e.miss = m_miss; e.score = m_score;
    return e;
  endfunction

  // One frame: y_valid high >= 1 clk, optional padding to steer a spawn x, then a fall.
  task automatic frame(input int pad_obj, input int lo, input int hi);
    int k;
    y_valid = 1'b1;
    @(posedge clk_vga); #1;
    if (pad_obj != 0) begin
      k = 0;
      while (!(spawn_pos(m_lfsr, pad_obj - 1) >= lo && spawn_pos(m_lfsr, pad_obj - 1) <= hi) &&
             k < 600) begin
        @(posedge clk_vga); #1;
        k++;
      end
      if (k >= 600) check("spawn_pad_search", 32'(k), 32'(0));
    end
    if (game_en) model_tick(int'(x_begin));
    else begin m_hit = 0; m_miss = 0; end
    q.push_back(snap());
    y_valid = 1'b0;
    repeat (2) begin @(posedge clk_vga); #1; end
    y_valid = 1'b1;
  endtask

  // Monitor: on each y_valid fall, outputs must be unchanged until the next edge, then match.
  bit       mon_prev_ok = 1'b0;
  exp_t     prev;
  bit [1:0] last_hit, last_miss;

  initial begin
    exp_t e;
    forever begin
      @(negedge y_valid);
      #1;
      if (mon_prev_ok) begin
        check("pre_tick_y1", 32'(obj1_y_begin), 32'(prev.y1));
        check("pre_tick_y2", 32'(obj2_y_begin), 32'(prev.y2));
      end
      @(posedge clk_vga); #2;
      if (q.size() == 0) begin
        check("scoreboard_underflow", 32'(0), 32'(1));
      end else begin
        e = q.pop_front();
        check("obj1_x", 32'(obj1_x_begin), 32'(e.x1));
        check("obj1_y", 32'(obj1_y_begin), 32'(e.y1));
        check("obj2_x", 32'(obj2_x_begin), 32'(e.x2));
        check("obj2_y", 32'(obj2_y_begin), 32'(e.y2));
        check("end_show1", 32'(end_show1), 32'(e.es1));
        check("end_show2", 32'(end_show2), 32'(e.es2));
        check("hit_pulse", 32'(hit_pulse), 32'(e.hit));
        check("miss_pulse", 32'(miss_pulse), 32'(e.miss));
`ifdef OBJ_SCORE_EN
        check("score", 32'(score), 32'(e.score));
`endif
        prev        = e;
        mon_prev_ok = 1'b1;
        last_hit    = hit_pulse;
        last_miss   = miss_pulse;
      end
      @(posedge clk_vga); #2;
      check("hit_pulse_width", 32'(hit_pulse), 32'(0));
      check("miss_pulse_width", 32'(miss_pulse), 32'(0));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rst = 1'b1; game_en = 1'b1; y_valid = 1'b1; x_begin = 12'd1000;
    repeat (2) @(posedge clk_vga);
    #2;
    check("rst_obj1_x", 32'(obj1_x_begin), 32'(0));
    check("rst_obj1_y", 32'(obj1_y_begin), 32'(0));
    check("rst_obj2_x", 32'(obj2_x_begin), 32'(0));
    check("rst_obj2_y", 32'(obj2_y_begin), 32'(0));
    check("rst_end_show1", 32'(end_show1), 32'(1));
    check("rst_end_show2", 32'(end_show2), 32'(1));
    check("rst_hit", 32'(hit_pulse), 32'(0));
    check("rst_miss", 32'(miss_pulse), 32'(0));
`ifdef OBJ_SCORE_EN
    check("rst_score", 32'(score), 32'(0));
`endif
    rst = 1'b0;
    model_reset();

    // Spawn: obj2 on tick 15, obj1 on tick 30, both steered to x in [200,259].
    repeat (14) frame(0, 0, 0);
    check("obj2_hidden_t14", 32'(end_show2), 32'(1));
    frame(2, 200, 259);
    check("obj2_shown_t15", 32'(end_show2), 32'(0));
    repeat (14) frame(0, 0, 0);
    check("obj1_hidden_t29", 32'(end_show1), 32'(1));
    frame(1, 200, 259);
    check("obj1_shown_t30", 32'(end_show1), 32'(0));
    check("obj1_spawn_y", 32'(obj1_y_begin), 32'(0));
    check("obj1_spawn_x_lt600", 32'(obj1_x_begin < 12'd600), 32'(1));
    check("obj2_y_at_t30", 32'(obj2_y_begin), 32'(30));

    // Fall to y = 100, then three plain steps.
    g = 0;
    while (m_y[0] != 100 && g < 400) begin frame(0, 0, 0); g++; end
    check("obj1_reach_y100", 32'(obj1_y_begin), 32'(100));
    for (int k = 1; k <= 3; k++) begin
      frame(0, 0, 0);
      check("fall_step_y", 32'(obj1_y_begin), 32'(100 + 2 * k));
    end

    // Freeze for 5 frames.
    game_en = 1'b0;
    repeat (5) frame(0, 0, 0);
    check("freeze_y1", 32'(obj1_y_begin), 32'(106));
    check("freeze_y2", 32'(obj2_y_begin), 32'(136));
    check("freeze_es1", 32'(end_show1), 32'(0));
    game_en = 1'b1;

    // An edge seen while disabled is dropped even if game_en returns while y_valid is low.
    y_valid = 1'b1;
    @(posedge clk_vga); #1;
    game_en = 1'b0;
    m_hit = 0; m_miss = 0;
    q.push_back(snap());
    y_valid = 1'b0;
    @(posedge clk_vga); #1;
    game_en = 1'b1;
    @(posedge clk_vga); #1;
    y_valid = 1'b1;
    @(posedge clk_vga); #1;
    check("discard_y1", 32'(obj1_y_begin), 32'(106));

    // Simultaneous hit: obj1 at y = 382, obj2 at y = 412, both inside the box at x_begin = 200.
    g = 0;
    while (m_y[0] != 382 && g < 400) begin frame(0, 0, 0); g++; end
    check("obj1_reach_y382", 32'(obj1_y_begin), 32'(382));
    check("obj2_at_y412", 32'(obj2_y_begin), 32'(412));
    x_begin = 12'd200;
    frame(0, 0, 0);
    check("double_hit", 32'(last_hit), 32'(3));
    check("hit_es1", 32'(end_show1), 32'(1));
    check("hit_es2", 32'(end_show2), 32'(1));
`ifdef OBJ_SCORE_EN
    check("double_hit_score", 32'(score), 32'(2));
`endif
    x_begin = 12'd1000;

    // 10 HIT ticks + 30 WAIT ticks: respawn on the 40th tick after the hit.
    repeat (39) frame(0, 0, 0);
    check("post_hit_hidden_39", 32'(end_show1), 32'(1));
    frame(0, 0, 0);
    check("post_hit_respawn_40", 32'(end_show1), 32'(0));
    check("post_hit_respawn_y", 32'(obj1_y_begin), 32'(0));

    // Both fall in lockstep and leave the screen together at y = 440.
    g = 0;
    while (m_miss == 2'b00 && g < 400) begin frame(0, 0, 0); g++; end
    check("double_miss", 32'(last_miss), 32'(3));
    check("miss_y_held", 32'(obj1_y_begin), 32'(440));
    check("miss_es1", 32'(end_show1), 32'(1));

    // Reset while falling at y = 200.
    g = 0;
    while (!(m_st[0] == MFall && m_y[0] == 200) && g < 400) begin frame(0, 0, 0); g++; end
    check("obj1_reach_y200", 32'(obj1_y_begin), 32'(200));
    rst = 1'b1;
    @(posedge clk_vga); #2;
    check("midrst_es1", 32'(end_show1), 32'(1));
    check("midrst_y1", 32'(obj1_y_begin), 32'(0));
    check("midrst_x1", 32'(obj1_x_begin), 32'(0));
    check("midrst_hit", 32'(hit_pulse), 32'(0));
    check("midrst_miss", 32'(miss_pulse), 32'(0));
`ifdef OBJ_SCORE_EN
    check("midrst_score", 32'(score), 32'(0));
`endif
    rst = 1'b0;
    mon_prev_ok = 1'b0;
    model_reset();
    repeat (3) frame(0, 0, 0);

    repeat (4) @(posedge clk_vga);
    #2;
    check("scoreboard_drained", 32'(q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
